// File: rtl/imu_pkg.sv
// Shared definitions for the IMU frame averager: channel map, defaults,
// FSM state type and the averaging arithmetic helper.
package imu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 6;

  localparam int CH_AX = 0;
  localparam int CH_AY = 1;
  localparam int CH_AZ = 2;
  localparam int CH_GX = 3;
  localparam int CH_GY = 4;
  localparam int CH_GZ = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } imu_state_t;

  // Sign-extends an acc_w-bit two's complement value held in the low bits,
  // then arithmetic-shifts it right, which floors towards minus infinity.
  function automatic logic signed [31:0] avg_shift(input logic [31:0] raw,
                                                   input int acc_w,
                                                   input int log2);
    logic signed [31:0] ext;
    ext = signed'(raw << (32 - acc_w)) >>> (32 - acc_w);
    return ext >>> log2;
  endfunction

endpackage

// File: rtl/imu_frame_averager_accumulator.sv
// Per-channel running sum; avg reflects the sum including the sample being
// added this cycle so the frame can be captured on the completing sample.
module imu_ch_accumulator
  import imu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       add_en,
  input  logic [DATA_W-1:0]          sample,
  output logic [DATA_W+AVG_LOG2-1:0] acc,
  output logic [DATA_W-1:0]          avg
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] sum;

  assign sample_ext = ACC_W'(signed'(sample));
  assign sum        = acc + (add_en ? sample_ext : '0);
  assign avg        = DATA_W'(avg_shift(32'(sum), ACC_W, AVG_LOG2));

  // load restarts the sum from this sample; clear discards it entirely
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= sample_ext;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/imu_frame_averager.sv
// Averages 2^AVG_LOG2 in-order rounds of IMU channel samples into one packed
// frame on a valid/ready output, flagging channel-order errors and overruns.
module imu_frame_averager
  import imu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int AVG_LOG2 = 2,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_enable,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic [7:0]               frame_seq,
  output logic                     sync_err,
  output logic                     overrun,
  output logic [7:0]               overrun_cnt
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'((1 << AVG_LOG2) - 1);

  imu_state_t state_q, state_d;
  logic [CH_W-1:0]  ch_exp;
  logic [RND_W-1:0] round_cnt;
  logic [7:0]       seq_cnt;
  logic             active, disable_now, hit, miss, restart, complete;
  logic [NUM_CH*DATA_W-1:0] avg_flat;
  logic [ACC_W-1:0]         acc_mon [NUM_CH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable takes priority over any sample decode, so it also masks sync_err
  always_comb begin
    state_d     = state_q;
    active      = 1'b0;
    disable_now = 1'b0;
    case (state_q)
      IDLE:  if (cfg_enable) state_d = ACCUM;
      ACCUM: begin
        if (cfg_enable) begin
          active = 1'b1;
        end else begin
          disable_now = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hit      = active && in_valid && (in_ch == ch_exp);
    miss     = active && in_valid && (in_ch != ch_exp);
    restart  = miss && (in_ch == '0);
    complete = hit && (ch_exp == LAST_CH) && (round_cnt == LAST_RND);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || state_q == IDLE || disable_now) begin
      ch_exp    <= '0;
      round_cnt <= '0;
    end else if (miss) begin
      ch_exp    <= restart ? CH_W'(1) : '0;
      round_cnt <= '0;
    end else if (hit) begin
      if (ch_exp == LAST_CH) begin
        ch_exp    <= '0;
        round_cnt <= (round_cnt == LAST_RND) ? '0 : round_cnt + 1'b1;
      end else begin
        ch_exp <= ch_exp + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic ch_add, ch_load, ch_clear;
    assign ch_add   = hit && (ch_exp == CH_W'(k));
    assign ch_load  = restart && (k == 0);
    assign ch_clear = disable_now || miss || complete;

    imu_ch_accumulator #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (ch_clear),
      .load    (ch_load),
      .add_en  (ch_add),
      .sample  (in_data),
      .acc     (acc_mon[k]),
      .avg     (avg_flat[k*DATA_W +: DATA_W])
    );
  end

  // A held frame is never overwritten; a completion that cannot load is dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_seq   <= '0;
      seq_cnt     <= '0;
      sync_err    <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      sync_err <= miss;
      overrun  <= 1'b0;
      if (complete) begin
        seq_cnt <= seq_cnt + 8'd1;
        if (!frame_valid || frame_ready) begin
          frame_valid <= 1'b1;
          frame_data  <= avg_flat;
          frame_seq   <= seq_cnt;
        end else begin
          overrun <= 1'b1;
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imu_frame_averager.sv
// Directed bench for imu_frame_averager: expected frames go into a scoreboard
// queue and a negedge monitor compares them on every output handshake.
module tb_imu_frame_averager;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 6;
  localparam int AVG_LOG2 = 2;
  localparam int CH_W     = 3;
  localparam int FW       = NUM_CH * DATA_W;

  logic              clk;
  logic              reset_n;
  logic              cfg_enable;
  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              frame_valid;
  logic              frame_ready;
  logic [FW-1:0]     frame_data;
  logic [7:0]        frame_seq;
  logic              sync_err;
  logic              overrun;
  logic [7:0]        overrun_cnt;

  int checks = 0;
  int passes = 0;
  int sync_pulses = 0;
  int overrun_pulses = 0;
  int base;

  logic [FW-1:0]     exp_data_q [$];
  logic [7:0]        exp_seq_q  [$];
  logic [DATA_W-1:0] vals [NUM_CH];

  imu_frame_averager #(
    .DATA_W   (DATA_W),
    .NUM_CH   (NUM_CH),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_enable  (cfg_enable),
    .in_valid    (in_valid),
    .in_ch       (in_ch),
    .in_data     (in_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_seq   (frame_seq),
    .sync_err    (sync_err),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] data);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendSamples(input int n);
    for (int i = 0; i < n; i++) applyStimulus(CH_W'(i % NUM_CH), vals[i % NUM_CH]);
  endtask

  task automatic setVals(input logic [FW-1:0] packed_vals);
    for (int k = 0; k < NUM_CH; k++) vals[k] = packed_vals[k*DATA_W +: DATA_W];
  endtask

  task automatic pushExp(input logic [FW-1:0] d, input logic [7:0] s);
    exp_data_q.push_back(d);
    exp_seq_q.push_back(s);
  endtask

  // Monitor: pulse counters plus scoreboard compare on each handshake
  always @(negedge clk) begin : monitor
    logic [FW-1:0] ed;
    logic [7:0]    es;
    if (sync_err) sync_pulses++;
    if (overrun) overrun_pulses++;
    if (reset_n && frame_valid && frame_ready) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb_unexpected: frame seq %0d presented, none expected", frame_seq);
      end else begin
        ed = exp_data_q.pop_front();
        es = exp_seq_q.pop_front();
        checkOutput("frame_data", 128'(frame_data), 128'(ed));
        checkOutput("frame_seq", 128'(frame_seq), 128'(es));
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    cfg_enable  = 1'b0;
    in_valid    = 1'b0;
    in_ch       = '0;
    in_data     = '0;
    frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_frame_valid", 128'(frame_valid), 0);
    checkOutput("rst_frame_data", 128'(frame_data), 0);
    checkOutput("rst_frame_seq", 128'(frame_seq), 0);
    checkOutput("rst_sync_err", 128'(sync_err), 0);
    checkOutput("rst_overrun", 128'(overrun), 0);
    checkOutput("rst_overrun_cnt", 128'(overrun_cnt), 0);
    reset_n    = 1'b1;
    cfg_enable = 1'b1;
    idle(1);

    $display("[TB] test 1: basic in-order frame");
    frame_ready = 1'b1;
    setVals(96'h0006_0005_0004_0003_0002_0001);
    pushExp(96'h0006_0005_0004_0003_0002_0001, 8'd0);
    sendSamples(23);
    checkOutput("t1_valid_before_last", 128'(frame_valid), 0);
    applyStimulus(CH_W'(5), vals[5]);
    checkOutput("t1_valid_after_last", 128'(frame_valid), 1);
    idle(1);
    checkOutput("t1_valid_cleared", 128'(frame_valid), 0);

    $display("[TB] test 2: signed and extreme values");
    pushExp(96'h0000_FFFF_0003_8000_7FFF_FFFE, 8'd1);
    for (int r = 0; r < 4; r++) begin
      setVals({(r < 3) ? 16'h0001 : 16'h0000, 16'hFFFF, 16'h0003,
               16'h8000, 16'h7FFF, (r == 0) ? 16'hFFFF : 16'hFFFE});
      sendSamples(NUM_CH);
    end
    idle(1);

    $display("[TB] test 3: backpressure and overrun");
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    base = overrun_pulses;
    setVals(96'h003C_0032_0028_001E_0014_000A);
    pushExp(96'h003C_0032_0028_001E_0014_000A, 8'd0);
    sendSamples(24);
    setVals(96'h0007_0007_0007_0007_0007_0007);
    sendSamples(24);
    idle(1);
    checkOutput("t3_overrun_pulses", 128'(overrun_pulses - base), 1);
    checkOutput("t3_overrun_cnt", 128'(overrun_cnt), 1);
    checkOutput("t3_held_seq", 128'(frame_seq), 0);
    checkOutput("t3_held_data", 128'(frame_data), 128'(96'h003C_0032_0028_001E_0014_000A));
    checkOutput("t3_held_valid", 128'(frame_valid), 1);
    frame_ready = 1'b1;
    idle(1);
    setVals(96'h0600_0500_0400_0300_0200_0100);
    pushExp(96'h0600_0500_0400_0300_0200_0100, 8'd2);
    sendSamples(24);
    idle(1);
    checkOutput("t3_overrun_cnt_after", 128'(overrun_cnt), 1);

    $display("[TB] test 4: channel order errors");
    setVals(96'h0018_0014_0010_000C_0008_0005);
    base = sync_pulses;
    applyStimulus(CH_W'(0), 16'd100);
    applyStimulus(CH_W'(1), 16'd100);
    applyStimulus(CH_W'(3), 16'd999);
    idle(1);
    checkOutput("t4_sync_drop", 128'(sync_pulses - base), 1);
    pushExp(96'h0018_0014_0010_000C_0008_0005, 8'd3);
    sendSamples(24);
    idle(1);
    base = sync_pulses;
    pushExp(96'h0018_0014_0010_000C_0008_0005, 8'd4);
    applyStimulus(CH_W'(0), 16'd100);
    applyStimulus(CH_W'(1), 16'd100);
    applyStimulus(CH_W'(0), vals[0]);
    for (int k = 1; k < NUM_CH; k++) applyStimulus(CH_W'(k), vals[k]);
    sendSamples(18);
    idle(1);
    checkOutput("t4_sync_restart", 128'(sync_pulses - base), 1);

    $display("[TB] test 5: handshake and completion together");
    frame_ready = 1'b0;
    setVals(96'h0066_0055_0044_0033_0022_0011);
    pushExp(96'h0066_0055_0044_0033_0022_0011, 8'd5);
    sendSamples(24);
    checkOutput("t5_first_valid", 128'(frame_valid), 1);
    base = overrun_pulses;
    setVals(96'h6000_5000_4000_3000_2000_1000);
    pushExp(96'h6000_5000_4000_3000_2000_1000, 8'd6);
    sendSamples(23);
    frame_ready = 1'b1;
    applyStimulus(CH_W'(5), vals[5]);
    checkOutput("t5_valid_kept", 128'(frame_valid), 1);
    checkOutput("t5_new_seq", 128'(frame_seq), 6);
    idle(1);
    checkOutput("t5_no_overrun", 128'(overrun_pulses - base), 0);
    checkOutput("t5_valid_cleared", 128'(frame_valid), 0);

    $display("[TB] test 6: reset and disable mid-round");
    frame_ready = 1'b0;
    setVals(96'h0123_0123_0123_0123_0123_0123);
    sendSamples(24);
    checkOutput("t6_pending_before_reset", 128'(frame_valid), 1);
    sendSamples(10);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    checkOutput("t6_reset_valid", 128'(frame_valid), 0);
    checkOutput("t6_reset_seq", 128'(frame_seq), 0);
    checkOutput("t6_reset_overrun_cnt", 128'(overrun_cnt), 0);
    idle(1);
    frame_ready = 1'b1;
    setVals(96'h0070_0060_0050_0040_0030_0020);
    pushExp(96'h0070_0060_0050_0040_0030_0020, 8'd0);
    sendSamples(23);
    checkOutput("t6_reset_fresh_round", 128'(frame_valid), 0);
    applyStimulus(CH_W'(5), vals[5]);
    idle(1);
    frame_ready = 1'b0;
    setVals(96'h0A06_0A05_0A04_0A03_0A02_0A01);
    pushExp(96'h0A06_0A05_0A04_0A03_0A02_0A01, 8'd1);
    sendSamples(24);
    sendSamples(10);
    base = sync_pulses;
    cfg_enable = 1'b0;
    applyStimulus(CH_W'(2), 16'h0055);
    idle(1);
    checkOutput("t6_disable_no_sync", 128'(sync_pulses - base), 0);
    checkOutput("t6_disable_keeps_frame", 128'(frame_valid), 1);
    checkOutput("t6_disable_keeps_seq", 128'(frame_seq), 1);
    cfg_enable = 1'b1;
    idle(1);
    frame_ready = 1'b1;
    setVals(96'h0B06_0B05_0B04_0B03_0B02_0B01);
    pushExp(96'h0B06_0B05_0B04_0B03_0B02_0B01, 8'd2);
    sendSamples(23);
    checkOutput("t6_disable_fresh_round", 128'(frame_valid), 0);
    applyStimulus(CH_W'(5), vals[5]);
    checkOutput("t6_final_valid", 128'(frame_valid), 1);
    idle(2);

    checkOutput("sb_drained", 128'(exp_data_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
